// File: rtl/uart_rx_fifo_if.sv
// Receive-side byte stream: FIFO head data, valid/ready handshake and occupancy.
// The master (receiver) drives data/valid/level; the slave (consumer) drives ready.
interface uart_rx_fifo_if #(
    parameter int FIFO_AW = 4
) ();
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready;
    logic [FIFO_AW:0] level;

    modport master (
        output out_data,
        output out_valid,
        output level,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  level,
        output out_ready
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver (5-8 data bits, optional parity) feeding a first-word-fall-through byte FIFO.
// Latency: byte written the cycle after the mid-stop-bit sample, out_valid one cycle later.
// Backpressure: out_ready pops the head; a good frame arriving to a full FIFO without a pop is dropped with overrun.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int FIFO_AW      = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           uart_rxd,
    uart_rx_fifo_if.master rx_if,
    output logic           perr,
    output logic           ferr,
    output logic           overrun
);

    localparam int              DEPTH    = 1 << FIFO_AW;
    localparam int              CW       = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0]   HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]   BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      LAST_BIT = 3'(DATA_BITS - 1);
    localparam logic            ODD      = (PARITY == 1);
    localparam logic [FIFO_AW:0] CNT_FULL = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t             state;
    logic               rx_meta;
    logic               rxs;
    logic [CW-1:0]      cnt;
    logic [2:0]         bit_idx;
    logic [7:0]         shreg;
    logic               par_err;
    logic               wr_pend;
    logic [7:0]         wr_dat;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               full;
    logic               pop;
    logic               wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= uart_rxd;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par_err <= 1'b0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
            wr_pend <= 1'b0;
            wr_dat  <= '0;
        end else begin
            perr    <= 1'b0;
            ferr    <= 1'b0;
            wr_pend <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!rxs) begin
                        cnt   <= '0;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (cnt == HALF_END) begin
                        cnt <= '0;
                        // A start bit that has gone high again by mid-bit is a glitch.
                        if (rxs) begin
                            state <= S_IDLE;
                        end else begin
                            bit_idx <= '0;
                            shreg   <= '0;
                            par_err <= 1'b0;
                            state   <= S_DATA;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (cnt == BIT_END) begin
                        cnt            <= '0;
                        shreg[bit_idx] <= rxs;
                        if (bit_idx == LAST_BIT) begin
                            state <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_PARITY: begin
                    if (cnt == BIT_END) begin
                        cnt     <= '0;
                        par_err <= ((^shreg) ^ rxs) != ODD;
                        state   <= S_STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (cnt == BIT_END) begin
                        cnt <= '0;
                        if (!rxs) begin
                            ferr  <= 1'b1;
                            state <= S_BREAK;
                        end else if (par_err) begin
                            perr  <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            wr_pend <= 1'b1;
                            wr_dat  <= shreg;
                            state   <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_BREAK: begin
                    if (rxs) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // The full/pop decision is taken in the write cycle so a pop in that same cycle frees the slot.
    assign full    = (count == CNT_FULL);
    assign pop     = rx_if.out_valid && rx_if.out_ready;
    assign wr      = wr_pend && (!full || pop);
    assign overrun = wr_pend && full && !pop;

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            case ({wr, pop})
                2'b10:   count <= count + (FIFO_AW + 1)'(1);
                2'b01:   count <= count - (FIFO_AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign rx_if.out_valid = (count != '0);
    assign rx_if.out_data  = rx_if.out_valid ? mem[rd_ptr] : 8'h00;
    assign rx_if.level     = count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: an 8N1 instance and a 7E1 instance, both with a 4-entry FIFO.
// Expected bytes are queued when a frame is sent; monitors pop and compare on every handshake.
module tb_uart_rx_fifo;
    localparam int C = 16;
    localparam int H = C / 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rxd0  = 1'b1;
    logic rxd1  = 1'b1;
    logic perr0, ferr0, ovr0, perr1, ferr1, ovr1;

    always #5 clk = ~clk;

    uart_rx_fifo_if #(.FIFO_AW(2)) if0 ();
    uart_rx_fifo_if #(.FIFO_AW(2)) if1 ();

    uart_rx_fifo #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .FIFO_AW(2)) u0 (
        .clk(clk), .rst_n(rst_n), .uart_rxd(rxd0), .rx_if(if0),
        .perr(perr0), .ferr(ferr0), .overrun(ovr0));
    uart_rx_fifo #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY(2), .FIFO_AW(2)) u1 (
        .clk(clk), .rst_n(rst_n), .uart_rxd(rxd1), .rx_if(if1),
        .perr(perr1), .ferr(ferr1), .overrun(ovr1));

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int exp_perr[2] = '{0, 0};
    int exp_ferr[2] = '{0, 0};
    int exp_ovr[2]  = '{0, 0};
    int got_perr[2] = '{0, 0};
    int got_ferr[2] = '{0, 0};
    int got_ovr[2]  = '{0, 0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: compare on each accepted byte, count flag pulse cycles.
    always @(negedge clk) begin
        if (rst_n) begin
            if (if0.out_valid && if0.out_ready) begin
                if (q0.size() == 0) check("u0_unexpected_pop", 1, 0);
                else begin
                    check("u0_pop_data", if0.out_data, q0[0]);
                    void'(q0.pop_front());
                end
            end
            if (perr0) got_perr[0]++;
            if (ferr0) got_ferr[0]++;
            if (ovr0)  got_ovr[0]++;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (if1.out_valid && if1.out_ready) begin
                if (q1.size() == 0) check("u1_unexpected_pop", 1, 0);
                else begin
                    check("u1_pop_data", if1.out_data, q1[0]);
                    void'(q1.pop_front());
                end
            end
            if (perr1) got_perr[1]++;
            if (ferr1) got_ferr[1]++;
            if (ovr1)  got_ovr[1]++;
        end
    end

    task automatic chk_state(input int u, input string tag);
        if (u == 0) begin
            check({tag, "_u0_level"}, if0.level, q0.size());
            check({tag, "_u0_valid"}, if0.out_valid, q0.size() != 0);
        end else begin
            check({tag, "_u1_level"}, if1.level, q1.size());
            check({tag, "_u1_valid"}, if1.out_valid, q1.size() != 0);
        end
        check({tag, "_perr_cnt"}, got_perr[u], exp_perr[u]);
        check({tag, "_ferr_cnt"}, got_ferr[u], exp_ferr[u]);
        check({tag, "_ovr_cnt"},  got_ovr[u],  exp_ovr[u]);
    endtask

    task automatic set_line(input int u, input logic v);
        if (u == 0) rxd0 = v;
        else        rxd1 = v;
    endtask

    // Sends one frame; the reference decides its fate from the frame rules and FIFO occupancy.
    // pop_pulse raises u0 out_ready for exactly the cycle in which the byte is written.
    task automatic send(input int u, input logic [7:0] d, input bit bad_par,
                        input bit bad_stop, input bit pop_pulse);
        int db;
        int np;
        int nb;
        int sz;
        logic [7:0] v;
        logic bits [0:11];
        db = (u == 0) ? 8 : 7;
        np = (u == 0) ? 0 : 1;
        v  = (u == 0) ? d : (d & 8'h7F);
        bits[0] = 1'b0;
        for (int k = 0; k < db; k++) bits[1 + k] = v[k];
        if (np != 0) bits[1 + db] = (^v) ^ bad_par;
        bits[1 + db + np] = !bad_stop;
        nb = 2 + db + np;
        sz = (u == 0) ? q0.size() : q1.size();
        if (bad_stop)                   exp_ferr[u]++;
        else if (bad_par)               exp_perr[u]++;
        else if (sz >= 4 && !pop_pulse) exp_ovr[u]++;
        else if (u == 0)                q0.push_back(v);
        else                            q1.push_back(v);
        @(posedge clk);
        #1;
        fork
            begin
                for (int i = 0; i < nb; i++) begin
                    set_line(u, bits[i]);
                    repeat (C) @(posedge clk);
                    #1;
                end
            end
            begin
                if (pop_pulse) begin
                    repeat (3 + H + (nb - 1) * C) @(posedge clk);
                    #1 if0.out_ready = 1'b1;
                    @(posedge clk);
                    #1 if0.out_ready = 1'b0;
                end
            end
        join
    endtask

    task automatic drain(input int u);
        @(posedge clk);
        #1;
        if (u == 0) if0.out_ready = 1'b1; else if1.out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        if (u == 0) if0.out_ready = 1'b0; else if1.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        bit bp;
        if0.out_ready = 1'b0;
        if1.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_u0_valid", if0.out_valid, 0);
        check("rst_u0_level", if0.level, 0);
        check("rst_u0_data",  if0.out_data, 0);
        check("rst_u0_flags", {perr0, ferr0, ovr0}, 0);
        check("rst_u1_valid", if1.out_valid, 0);
        check("rst_u1_flags", {perr1, ferr1, ovr1}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // Single byte held, then one-cycle pop.
        send(0, 8'hA5, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_state(0, "a5_held");
        check("a5_head", if0.out_data, q0[0]);
        if0.out_ready = 1'b1;
        @(posedge clk);
        #1 if0.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_state(0, "a5_popped");

        // Even parity: good then bad parity bit.
        send(1, 8'h35, 0, 0, 0);
        send(1, 8'h35, 1, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_state(1, "parity");
        drain(1);
        chk_state(1, "parity_drained");

        // Framing error followed by a long break, then a normal frame.
        send(0, 8'h3C, 0, 1, 0);
        repeat (100) @(posedge clk);
        #1 rxd0 = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk_state(0, "break");
        send(0, 8'h11, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_state(0, "after_break");
        drain(0);

        // Short low glitch on an idle line.
        rxd0 = 1'b0;
        repeat (5) @(posedge clk);
        #1 rxd0 = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk_state(0, "glitch");
        send(0, 8'h7E, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_state(0, "after_glitch");
        drain(0);

        // Overrun on a full FIFO, then the same with a pop coinciding with the write.
        for (int i = 1; i <= 5; i++) send(0, 8'(i), 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_state(0, "overrun");
        drain(0);
        chk_state(0, "overrun_drained");
        for (int i = 1; i <= 4; i++) send(0, 8'(i), 0, 0, 0);
        send(0, 8'h05, 0, 0, 1);
        repeat (2) @(posedge clk);
        #1;
        chk_state(0, "full_pop_push");
        drain(0);
        chk_state(0, "wrap_drained");

        // Asynchronous reset in the middle of a data bit.
        send(0, 8'($urandom_range(0, 255)), 0, 0, 0);
        send(0, 8'($urandom_range(0, 255)), 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_state(0, "pre_reset");
        fork
            send(0, 8'h55, 0, 0, 0);
            begin
                repeat (H + 3 * C) @(posedge clk);
                #2 rst_n = 1'b0;
                #1;
                check("arst_valid", if0.out_valid, 0);
                check("arst_level", if0.level, 0);
                check("arst_data",  if0.out_data, 0);
                check("arst_flags", {perr0, ferr0, ovr0}, 0);
            end
        join
        q0.delete();
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        send(0, 8'h66, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_state(0, "after_reset");
        drain(0);

        // Randomized traffic with random consumer readiness.
        for (int i = 0; i < 8; i++) begin
            rd = 8'($urandom_range(0, 255));
            fork
                send(0, rd, 0, 0, 0);
                begin
                    repeat (9 * C) begin
                        @(posedge clk);
                        #1 if0.out_ready = 1'($urandom_range(0, 1));
                    end
                end
            join
            drain(0);
        end
        chk_state(0, "rand_u0");
        for (int i = 0; i < 8; i++) begin
            rd = 8'($urandom_range(0, 127));
            bp = ($urandom_range(0, 3) == 0);
            fork
                send(1, rd, bp, 0, 0);
                begin
                    repeat (10 * C) begin
                        @(posedge clk);
                        #1 if1.out_ready = 1'($urandom_range(0, 1));
                    end
                end
            join
            drain(1);
        end
        chk_state(1, "rand_u1");
        chk_state(0, "final_u0");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with a configurable frame format and an on-chip receive FIFO. It turns the asynchronous serial input into bytes buffered for the core, so that loader logic can drain data with a valid/ready handshake instead of polling a one-shot READY strobe. It reports parity, framing and overrun errors and rejects glitch start bits.

## Interface
- CLKS_PER_BIT, 10416: clock cycles per bit at 100 MHz / 9600 baud; must be ≥ 4.
- DATA_BITS, 8: data bits per frame, range 5–8, sent LSB first.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- FIFO_AW, 4: FIFO address width; depth = 2**FIFO_AW entries.
- CLK  in  1  system clock; all logic on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- UART_RXD  in  1  serial input; idles high; asynchronous to CLK.
- OUT_DATA  out  8  FIFO head byte; upper 8-DATA_BITS bits are zero.
- OUT_VALID  out  1  FIFO not empty.
- OUT_READY  in  1  consumer accepts the head byte when OUT_VALID && OUT_READY.
- LEVEL  out  FIFO_AW+1  current FIFO occupancy.
- PERR  out  1  one-cycle pulse: parity mismatch, frame dropped.
- FERR  out  1  one-cycle pulse: stop bit sampled low, frame dropped.
- OVERRUN  out  1  one-cycle pulse: good frame dropped because FIFO full.

## Operation
- UART_RXD passes through a 2-FF synchroniser (reset to 1); all decisions use the synchronised value rxs.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: on rxs==0, clear baud counter and enter START.
- START: at counter == CLKS_PER_BIT/2-1 (integer division), sample rxs. If it is 1, the start is false: return to IDLE with no flags. If it is 0, clear the counter and enter DATA with bit index 0.
- DATA: sample at every counter == CLKS_PER_BIT-1, i.e. mid-bit. Shift the sample into bit[index]. After DATA_BITS samples, go to PARITY if PARITY!=0, else go to STOP.
- PARITY: sample one bit. For even parity the XOR of data bits and parity bit must be 0; for odd parity it must be 1. Latch the mismatch internally.
- STOP: sample one bit.
  - Stop bit 0: pulse FERR and enter BREAK. FERR takes priority over PERR, and only FERR pulses.
  - Else, parity mismatch: pulse PERR and go to IDLE.
  - Else, FIFO full and no pop this cycle: pulse OVERRUN and go to IDLE.
  - Else: push the byte and go to IDLE.
- BREAK: wait for rxs==1, then go to IDLE. A held-low line produces exactly one FERR.
- FIFO: circular buffer with FIFO_AW-bit read and write pointers that wrap modulo depth. Occupancy is held in a separate counter that drives LEVEL.
  - First-word fall-through: OUT_DATA equals the head entry whenever OUT_VALID=1.
  - Pop on OUT_VALID && OUT_READY. OUT_READY while empty is ignored.
  - Push and pop in the same cycle: both happen and LEVEL is unchanged. This holds when full, so no OVERRUN is raised. When empty, no bypass occurs: the pushed byte appears the next cycle.
- Error pulses never alter FIFO contents.

## Timing
- Reset (asynchronous assert, synchronous-release design) gives: state IDLE, pointers 0, LEVEL 0, OUT_VALID 0, PERR/FERR/OVERRUN 0, synchroniser 1, OUT_DATA 0. FIFO RAM content is don't-care.
- Reset mid-frame aborts the frame with no flags. Receive restarts only on a fresh falling edge after release.
- Start detection latency: UART_RXD falling edge reaches rxs after 2 CLK edges; START is entered 1 cycle later.
- Sample instants relative to START entry: start bit at CLKS_PER_BIT/2; bit k at CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT.
- Push and flag pulses occur on the cycle after the stop-bit sample. OUT_VALID rises on the following cycle.
- LEVEL and OUT_VALID update on the cycle after a push or pop.
- Back-to-back frames: IDLE is re-entered at mid-stop-bit, so the next start edge is accepted with no dead time.
- Tolerance: ±(CLKS_PER_BIT/2 − 1)/(frame bits · CLKS_PER_BIT) baud mismatch.

## Test plan
- CLKS_PER_BIT=16, 8N1; send 0xA5 with OUT_READY=0 → OUT_VALID=1, OUT_DATA=0xA5, LEVEL=1, no flags. Raise OUT_READY for 1 cycle → LEVEL=0, OUT_VALID=0.
- PARITY=2, DATA_BITS=7; send 0x35 with correct parity 0, then 0x35 with parity 1 → first pushed as 0x35, second dropped with a single PERR pulse, LEVEL=1.
- Stop bit forced low for 0x3C, then line held low 100 cycles, then high; then send 0x11 → exactly one FERR, nothing pushed, then 0x11 received normally.
- Low glitch of 5 cycles (less than 8) on an idle line → no state change visible, no flags, LEVEL=0. A following frame 0x7E is received correctly.
- FIFO_AW=2; send 5 frames 0x01..0x05 with OUT_READY=0 → LEVEL=4, OVERRUN on the 5th. Drain yields 0x01..0x04. Repeat with OUT_READY pulsed on the 5th push cycle → no OVERRUN, LEVEL stays 4, drain yields 0x02..0x05 (pointer wrap checked).
- Assert RST_N=0 mid-data-bit of frame 0x55 while LEVEL=2 → all outputs at reset values immediately (asynchronous). After release, frame 0x66 is received with LEVEL=1.
